// File: rtl/regfile_dump_reader.sv
// Debug readback engine: walks the register file read ports two registers
// at a time and streams the contents out one register per valid/ready beat.
module regfile_dump_reader #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned IDX_WIDTH  = 5
) (
  input  logic                  Clk,
  input  logic                  resetl,
  input  logic                  Start,
  input  logic [IDX_WIDTH-1:0]  StartReg,
  input  logic [IDX_WIDTH:0]    Count,
  output logic [IDX_WIDTH-1:0]  RA,
  output logic [IDX_WIDTH-1:0]  RB,
  input  logic [DATA_WIDTH-1:0] BusA,
  input  logic [DATA_WIDTH-1:0] BusB,
  output logic [DATA_WIDTH-1:0] DumpData,
  output logic [IDX_WIDTH-1:0]  DumpIdx,
  output logic                  DumpValid,
  input  logic                  DumpReady,
  output logic                  DumpLast,
  output logic                  Busy,
  output logic                  Done
);

  localparam int unsigned CNT_W  = IDX_WIDTH + 1;
  localparam int unsigned N_REGS = 2 ** IDX_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_SEND_A = 3'd2,
    S_SEND_B = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e                state_q;
  logic [IDX_WIDTH-1:0]  ptr_q;
  logic [CNT_W-1:0]      rem_q;
  logic [IDX_WIDTH-1:0]  ra_q;
  logic [IDX_WIDTH-1:0]  rb_q;
  logic [DATA_WIDTH-1:0] buf_b_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  busy_q;
  logic                  done_q;
  logic [CNT_W-1:0]      count_eff_c;

  // Zero or oversized counts mean "the whole register file".
  always_comb begin
    count_eff_c = Count;
    if (Count == '0 || Count > CNT_W'(N_REGS)) begin
      count_eff_c = CNT_W'(N_REGS);
    end
  end

  // Dump sequencer: state, address pointer, beat buffer and registered outputs.
  always_ff @(posedge Clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      buf_b_q <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            ptr_q   <= StartReg;
            rem_q   <= count_eff_c;
            ra_q    <= StartReg;
            rb_q    <= StartReg + IDX_WIDTH'(1);
            busy_q  <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          // Read data is sampled here; later regfile writes are not seen.
          buf_b_q <= BusB;
          data_q  <= BusA;
          idx_q   <= ptr_q;
          last_q  <= (rem_q == CNT_W'(1));
          valid_q <= 1'b1;
          state_q <= S_SEND_A;
        end
        S_SEND_A: begin
          if (DumpReady) begin
            if (rem_q == CNT_W'(1)) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rem_q   <= rem_q - CNT_W'(1);
              data_q  <= buf_b_q;
              idx_q   <= ptr_q + IDX_WIDTH'(1);
              last_q  <= (rem_q == CNT_W'(2));
              state_q <= S_SEND_B;
            end
          end
        end
        S_SEND_B: begin
          if (DumpReady) begin
            rem_q   <= rem_q - CNT_W'(1);
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (rem_q == CNT_W'(1)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              ptr_q   <= ptr_q + IDX_WIDTH'(2);
              ra_q    <= ptr_q + IDX_WIDTH'(2);
              rb_q    <= ptr_q + IDX_WIDTH'(3);
              state_q <= S_READ;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign RA        = ra_q;
  assign RB        = rb_q;
  assign DumpData  = data_q;
  assign DumpIdx   = idx_q;
  assign DumpValid = valid_q;
  assign DumpLast  = last_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule
